// File: rtl/interboard_tx_pkg.sv
// -----------------------------------------------------------------------------
// interboard_tx_pkg
// Shared message definitions for the board-to-board link: field widths,
// message type codes, transmitter FSM states and a packing helper.
// No ports (package).
// -----------------------------------------------------------------------------
package interboard_tx_pkg;

  localparam int MSG_TYPE_W = 3;
  localparam int MSG_NUM_W  = 5;
  localparam int MSG_W      = MSG_TYPE_W + MSG_NUM_W;

  // Width of the handshake phase timer; large enough for 10 ms at 100 MHz.
  localparam int TIMER_W = 20;

  typedef enum logic [MSG_TYPE_W-1:0] {
    MSG_NONE   = 3'd0,
    STATE_TURN = 3'd1,
    STATE_WIN  = 3'd2,
    SEL_NUM    = 3'd3,
    STATE_LOSE = 3'd4,
    STATE_DRAW = 3'd5
  } msg_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    DONE   = 2'd3
  } tx_state_e;

  // Wire format on the link: type in the top bits, number in the low bits.
  function automatic logic [MSG_W-1:0] pack_msg(
    input logic [MSG_TYPE_W-1:0] msg_type,
    input logic [MSG_NUM_W-1:0]  number
  );
    return {msg_type, number};
  endfunction

endpackage

// File: rtl/interboard_tx_if.sv
// -----------------------------------------------------------------------------
// interboard_tx_if
// Four-phase request/acknowledge link between boards.
//   tx_req  : request, driven by the transmitting board
//   tx_data : packed message {msg_type, number}, valid while tx_req is high
//   tx_ack  : acknowledge from the receiving board (asynchronous to us)
// Modports: master = transmitter side, slave = receiver side.
// -----------------------------------------------------------------------------
interface interboard_tx_if;

  logic                             tx_req;
  logic [interboard_tx_pkg::MSG_W-1:0] tx_data;
  logic                             tx_ack;

  modport master (output tx_req, output tx_data, input tx_ack);
  modport slave  (input tx_req, input tx_data, output tx_ack);

endinterface

// File: rtl/interboard_tx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : asynchronous active-low reset
//   clr : synchronous active-high clear
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else if (clr) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/interboard_tx.sv
// -----------------------------------------------------------------------------
// interboard_tx
// Queues short control messages in a 2-entry FIFO and sends them one at a
// time to the other board over a four-phase req/ack handshake, with a
// per-phase timeout.
//   clk            : system clock, rising edge
//   rst            : asynchronous active-low reset
//   interboard_rst : synchronous active-high clear from the other board
//   ctrl_en        : one-cycle send request
//   ctrl_msg_type  : message type code
//   ctrl_number    : message number field
//   link           : handshake link (tx_req, tx_data out; tx_ack in)
//   inter_ready    : one-cycle pulse when a message completes its handshake
//   busy           : FIFO non-empty or FSM not idle
//   overflow_err   : sticky, a request was dropped on a full FIFO
//   timeout_err    : sticky, a handshake phase timed out
// -----------------------------------------------------------------------------
module interboard_tx
  import interboard_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  interboard_rst,
  input  logic                  ctrl_en,
  input  logic [MSG_TYPE_W-1:0] ctrl_msg_type,
  input  logic [MSG_NUM_W-1:0]  ctrl_number,
  interboard_tx_if.master       link,
  output logic                  inter_ready,
  output logic                  busy,
  output logic                  overflow_err,
  output logic                  timeout_err
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic             ack_s;
  tx_state_e        state_reg;
  logic [MSG_W-1:0] fifo_mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             tx_req_reg;
  logic [MSG_W-1:0] tx_data_reg;
  logic             inter_ready_reg;
  logic             overflow_err_reg;
  logic             timeout_err_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic             pop;
  logic             push;
  logic             timer_expired;

  sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .clr (interboard_rst),
    .d   (link.tx_ack),
    .q   (ack_s)
  );

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop           = (state_reg == IDLE) && (count_reg != 2'd0);
  assign push          = ctrl_en && ((count_reg != 2'd2) || pop);
  assign timer_expired = (timer_reg == TIMER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      fifo_mem_reg[0] <= '0;
      fifo_mem_reg[1] <= '0;
    end else if (interboard_rst) begin
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      fifo_mem_reg[0] <= '0;
      fifo_mem_reg[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem_reg[wr_ptr_reg] <= pack_msg(ctrl_msg_type, ctrl_number);
        wr_ptr_reg               <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // tx_data is loaded on the way into REQ_HI and tx_req rises one cycle
  // later, so the data is settled at the receiver before the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      tx_req_reg       <= 1'b0;
      tx_data_reg      <= '0;
      inter_ready_reg  <= 1'b0;
      overflow_err_reg <= 1'b0;
      timeout_err_reg  <= 1'b0;
      timer_reg        <= '0;
    end else if (interboard_rst) begin
      state_reg        <= IDLE;
      tx_req_reg       <= 1'b0;
      tx_data_reg      <= '0;
      inter_ready_reg  <= 1'b0;
      overflow_err_reg <= 1'b0;
      timeout_err_reg  <= 1'b0;
      timer_reg        <= '0;
    end else begin
      inter_ready_reg <= 1'b0;
      if (ctrl_en && !push) begin
        overflow_err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pop) begin
            tx_data_reg <= fifo_mem_reg[rd_ptr_reg];
            timer_reg   <= '0;
            state_reg   <= REQ_HI;
          end
        end
        REQ_HI: begin
          timer_reg <= timer_reg + 20'd1;
          if (timer_expired) begin
            tx_req_reg      <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= IDLE;
          end else if (ack_s) begin
            tx_req_reg <= 1'b0;
            timer_reg  <= '0;
            state_reg  <= REQ_LO;
          end else begin
            tx_req_reg <= 1'b1;
          end
        end
        REQ_LO: begin
          timer_reg <= timer_reg + 20'd1;
          if (timer_expired) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= IDLE;
          end else if (!ack_s) begin
            inter_ready_reg <= 1'b1;
            state_reg       <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign link.tx_req  = tx_req_reg;
  assign link.tx_data = tx_data_reg;
  assign inter_ready  = inter_ready_reg;
  assign overflow_err = overflow_err_reg;
  assign timeout_err  = timeout_err_reg;
  assign busy         = (count_reg != 2'd0) || (state_reg != IDLE);

endmodule
